// File: rtl/elevator_pkg.sv
// Shared elevator types: button count, offer FSM states and the lowest-set-bit
// priority picker used by both the call front end and the controller.
package elevator_pkg;

  localparam int unsigned N_BTN = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } offer_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_BTN-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: 2-flop synchroniser, tick-sampled history and
// a one-cycle pulse on every debounced 0->1 transition.
module btn_debounce #(
  parameter int unsigned DEB_SAMPLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic press_pulse
);

  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic [DEB_SAMPLES-1:0] hist_q, hist_d;
  logic                   deb_q, deb_d;
  logic                   pulse_q, pulse_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    hist_d  = hist_q;
    if (tick) hist_d = {hist_q[DEB_SAMPLES-2:0], sync2_q};
    // State only moves on a unanimous history, otherwise it holds.
    deb_d = deb_q;
    if (&hist_q)       deb_d = 1'b1;
    else if (~|hist_q) deb_d = 1'b0;
    pulse_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      deb_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      deb_q   <= deb_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/call_input.sv
// Elevator panel input front end: debounces buttons, latches requests and
// offers them one at a time over valid/ready. CALL_CANCEL_EN: re-press cancels.
module call_input
  import elevator_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000,
  parameter int unsigned DEB_SAMPLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             working,
  input  logic [N_BTN-1:0] clear,
  input  logic             req_ready,
  output logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] press_pulse,
  output logic             req_valid,
  output logic [IDX_W-1:0] req_idx
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_c;

  // Free-running sample tick shared by all debouncers.
  always_comb begin
    tick_c = (cnt_q == CNT_W'(TICK_CYCLES - 1));
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick_c),
      .raw         (btn_raw[g]),
      .press_pulse (press_pulse[g])
    );
  end

  logic [N_BTN-1:0] button_q, button_d;
  logic [N_BTN-1:0] new_q, new_d;
  logic [N_BTN-1:0] set_v, cancel_v, ack_mask;
  logic             ack_c;
  offer_state_e     state_q, state_d;
  logic             req_valid_q, req_valid_d;
  logic [IDX_W-1:0] req_idx_q, req_idx_d;

  // Request latch: a fresh press sets, clear/cancel/handshake retire.
  always_comb begin
    ack_c    = (state_q == OFFER) && req_ready && working;
    ack_mask = '0;
    if (ack_c) ack_mask[req_idx_q] = 1'b1;
`ifdef CALL_CANCEL_EN
    cancel_v = press_pulse & button_q;
`else
    cancel_v = '0;
`endif
    set_v    = press_pulse & ~button_q;
    button_d = '0;
    new_d    = '0;
    if (working) begin
      button_d = (button_q & ~clear & ~cancel_v) | set_v;
      new_d    = (new_q & ~clear & ~cancel_v & ~ack_mask) | set_v;
    end
  end

  // Offer FSM; an offer is withdrawn whenever its latched request goes away.
  always_comb begin
    state_d   = state_q;
    req_idx_d = req_idx_q;
    unique case (state_q)
      IDLE: begin
        if (working && (|new_q)) begin
          state_d   = OFFER;
          req_idx_d = lowest_set(new_q);
        end
      end
      OFFER: begin
        if (!working || ack_c || !button_d[req_idx_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_valid_d = (state_d == OFFER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      button_q    <= '0;
      new_q       <= '0;
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_idx_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      button_q    <= button_d;
      new_q       <= new_d;
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_idx_q   <= req_idx_d;
    end
  end

  assign button    = button_q;
  assign req_valid = req_valid_q;
  assign req_idx   = req_idx_q;

endmodule

// File: tb/tb_call_input.sv
// Bench for call_input: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the panel front end.
module tb_call_input;
  import elevator_pkg::*;

  localparam int TICK = 4;
  localparam int DEB  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] btn_raw = '0;
  logic [15:0] clear = '0;
  logic        working = 1'b0;
  logic        req_ready = 1'b0;
  logic [15:0] button;
  logic [15:0] press_pulse;
  logic        req_valid;
  logic [3:0]  req_idx;

  call_input #(.TICK_CYCLES(TICK), .DEB_SAMPLES(DEB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .working     (working),
    .clear       (clear),
    .req_ready   (req_ready),
    .button      (button),
    .press_pulse (press_pulse),
    .req_valid   (req_valid),
    .req_idx     (req_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: run lengths of equal samples stand in for the history.
  int          m_cnt;
  logic [15:0] m_s1, m_s2, m_deb, m_pulse, m_button, m_new;
  int          run1[16];
  int          run0[16];
  logic        m_offer;
  int          m_idx;

  task automatic model_reset();
    m_cnt = 0; m_s1 = '0; m_s2 = '0; m_deb = '0; m_pulse = '0;
    m_button = '0; m_new = '0; m_offer = 1'b0; m_idx = 0;
    for (int i = 0; i < 16; i++) begin
      run1[i] = 0;
      run0[i] = DEB;
    end
  endtask

  task automatic model_step();
    logic        tick, ack;
    logic [15:0] n_deb, n_pulse, n_button, n_new;
    logic        b, nw, n_offer;
    int          n_idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick = (m_cnt == TICK - 1);
    for (int i = 0; i < 16; i++) begin
      n_deb[i] = m_deb[i];
      if (run1[i] >= DEB)      n_deb[i] = 1'b1;
      else if (run0[i] >= DEB) n_deb[i] = 1'b0;
      n_pulse[i] = n_deb[i] & ~m_deb[i];
      if (tick) begin
        if (m_s2[i]) begin
          if (run1[i] < DEB) run1[i]++;
          run0[i] = 0;
        end else begin
          if (run0[i] < DEB) run0[i]++;
          run1[i] = 0;
        end
      end
    end
    ack = m_offer && req_ready && working;
    for (int i = 0; i < 16; i++) begin
      b  = m_button[i];
      nw = m_new[i];
      if (ack && i == m_idx) nw = 1'b0;
      if (!working) begin
        b = 1'b0; nw = 1'b0;
      end else if (m_pulse[i] && !m_button[i]) begin
        b = 1'b1; nw = 1'b1;
`ifdef CALL_CANCEL_EN
      end else if (m_pulse[i] && m_button[i]) begin
        b = 1'b0; nw = 1'b0;
`endif
      end else if (clear[i]) begin
        b = 1'b0; nw = 1'b0;
      end
      n_button[i] = b;
      n_new[i]    = nw;
    end
    n_offer = m_offer;
    n_idx   = m_idx;
    if (!m_offer) begin
      if (working && m_new != 0) begin
        n_offer = 1'b1;
        for (int i = 0; i < 16; i++) if (m_new[i]) begin n_idx = i; break; end
      end
    end else if (!working || ack || !n_button[m_idx]) begin
      n_offer = 1'b0;
    end
    m_cnt = tick ? 0 : m_cnt + 1;
    m_s2 = m_s1; m_s1 = btn_raw;
    m_deb = n_deb; m_pulse = n_pulse;
    m_button = n_button; m_new = n_new;
    m_offer = n_offer; m_idx = n_idx;
  endtask

  int pulse_cnt[16];
  logic log_hs = 1'b0;
  int hs_q[$];

  task automatic compare();
    check("button", 32'(button), 32'(m_button));
    check("press_pulse", 32'(press_pulse), 32'(m_pulse));
    check("req_valid", 32'(req_valid), 32'(m_offer));
    if (m_offer) check("req_idx", 32'(req_idx), 32'(m_idx));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    for (int i = 0; i < 16; i++) if (press_pulse[i]) pulse_cnt[i]++;
    if (log_hs && req_valid && req_ready) hs_q.push_back(int'(req_idx));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic press(input int bit_i);
    btn_raw[bit_i] = 1'b1;
    run(40);
    btn_raw[bit_i] = 1'b0;
    run(30);
  endtask

  task automatic accept_and_clear(input logic [15:0] bits);
    req_ready = 1'b1; cycle(); req_ready = 1'b0;
    clear = bits; cycle(); clear = '0;
    run(2);
  endtask

  initial begin
    logic fired;
    model_reset();
    for (int i = 0; i < 16; i++) pulse_cnt[i] = 0;
    run(2);
    check("rst_button", 32'(button), 32'h0);
    check("rst_valid", 32'(req_valid), 32'h0);
    check("rst_idx", 32'(req_idx), 32'h0);
    rst_n = 1'b1;
    working = 1'b1;
    run(3);

    // Clean press, controller not ready.
    btn_raw[3] = 1'b1;
    run(40);
    check("clean_pulse_cnt", 32'(pulse_cnt[3]), 32'd1);
    check("clean_button", 32'(button), 32'h0008);
    check("clean_valid", 32'(req_valid), 32'd1);
    check("clean_idx", 32'(req_idx), 32'd3);
    btn_raw[3] = 1'b0;
    run(30);
    check("clean_idx_held", 32'(req_idx), 32'd3);
    req_ready = 1'b1; cycle(); req_ready = 1'b0;
    run(3);
    check("clean_after_hs_valid", 32'(req_valid), 32'd0);
    check("clean_after_hs_button", 32'(button), 32'h0008);
    clear = 16'h0008; cycle(); clear = '0;
    check("clean_cleared", 32'(button), 32'h0);

    // Bounce shorter than the debounce window.
    for (int k = 0; k < 10; k++) begin
      btn_raw[5] = ~btn_raw[5];
      run(6);
    end
    btn_raw[5] = 1'b0;
    run(30);
    check("bounce_pulse_cnt", 32'(pulse_cnt[5]), 32'd0);
    check("bounce_button", 32'(button), 32'h0);

    // Two simultaneous presses are offered lowest index first.
    log_hs = 1'b1;
    req_ready = 1'b1;
    btn_raw = 16'h0204;
    run(40);
    btn_raw = '0;
    run(30);
    req_ready = 1'b0;
    log_hs = 1'b0;
    check("order_hs_count", 32'(hs_q.size()), 32'd2);
    if (hs_q.size() == 2) begin
      check("order_first", 32'(hs_q[0]), 32'd2);
      check("order_second", 32'(hs_q[1]), 32'd9);
    end
    check("order_button", 32'(button), 32'h0204);
    clear = 16'h0204; cycle(); clear = '0;

    // Offer stays stable when a lower index arrives.
    press(7);
    press(1);
    check("stable_valid", 32'(req_valid), 32'd1);
    check("stable_idx", 32'(req_idx), 32'd7);
    req_ready = 1'b1; cycle(); req_ready = 1'b0;
    run(2);
    check("stable_next_valid", 32'(req_valid), 32'd1);
    check("stable_next_idx", 32'(req_idx), 32'd1);
    accept_and_clear(16'h0082);

    // Clear of the offered request withdraws it.
    press(7);
    check("withdraw_pre_valid", 32'(req_valid), 32'd1);
    clear = 16'h0080; cycle(); clear = '0;
    check("withdraw_valid", 32'(req_valid), 32'd0);
    check("withdraw_button", 32'(button), 32'h0);

    // Clear coincident with the press pulse: the press wins.
    btn_raw[4] = 1'b1;
    fired = 1'b0;
    for (int k = 0; k < 60 && !fired; k++) begin
      cycle();
      if (press_pulse[4]) begin
        clear = 16'h0010; cycle(); clear = '0;
        fired = 1'b1;
      end
    end
    check("coincide_pulse_seen", 32'(fired), 32'd1);
    check("coincide_button", 32'(button[4]), 32'd1);
    btn_raw[4] = 1'b0;
    run(30);
    accept_and_clear(16'h0010);

    // Dropping working mid-offer flushes everything.
    press(6);
    check("work_pre_valid", 32'(req_valid), 32'd1);
    working = 1'b0; cycle(); working = 1'b1;
    check("work_button", 32'(button), 32'h0);
    check("work_valid", 32'(req_valid), 32'd0);
    run(3);
    check("work_stays_idle", 32'(req_valid), 32'd0);

    // Second press of a latched bit.
    press(3);
    press(3);
`ifdef CALL_CANCEL_EN
    check("repress_button", 32'(button), 32'h0);
    check("repress_valid", 32'(req_valid), 32'd0);
`else
    check("repress_button", 32'(button), 32'h0008);
    check("repress_valid", 32'(req_valid), 32'd1);
`endif
    accept_and_clear(16'h0008);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0) btn_raw[$urandom_range(0, 15)] ^= 1'b1;
      req_ready = ($urandom_range(0, 3) == 0);
      clear = '0;
      if ($urandom_range(0, 15) == 0) clear[$urandom_range(0, 15)] = 1'b1;
      if (m_offer && $urandom_range(0, 31) == 0) clear[m_idx] = 1'b1;
      working = ($urandom_range(0, 199) != 0);
      cycle();
    end
    clear = '0; req_ready = 1'b0; working = 1'b1; btn_raw = '0;
    run(30);

    // Asynchronous reset with a pending offer.
    press(10);
    check("arst_pre_valid", 32'(req_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_button", 32'(button), 32'h0);
    check("arst_pulse", 32'(press_pulse), 32'h0);
    check("arst_valid", 32'(req_valid), 32'd0);
    check("arst_idx", 32'(req_idx), 32'd0);
    model_reset();
    run(2);
    rst_n = 1'b1;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/call_input.md
# call_input

Input-side front end of the elevator panel. Synchronises and debounces the 16 raw call/car buttons, and latches each debounced press as a pending request. It shows the latched vector on `button`, which feeds the display block's LED bank, and hands new requests one at a time to the elevator controller over a valid/ready handshake. Requests are cleared when the controller reports service.

## Interface
- `N_BTN`, 16: number of buttons; one bit per button on every vector port.
- `TICK_CYCLES`, 100_000: clk cycles per debounce sample (1 ms at 100 MHz).
- `DEB_SAMPLES`, 8: number of consecutive equal samples required to change debounced state. Range 2..16.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn_raw` in N_BTN: raw buttons, asynchronous to clk, active-high.
- `working` in 1: system enabled; when 0, all requests are dropped.
- `clear` in N_BTN: controller pulse; clears the corresponding latched request.
- `req_ready` in 1: controller accepts the offered request.
- `button` out N_BTN: latched pending requests (to display `button`/LED).
- `press_pulse` out N_BTN: one-cycle pulse per debounced rising edge.
- `req_valid` out 1: a new request is offered.
- `req_idx` out 4: index of the offered button; valid only when `req_valid`=1.

## Operation
- Synchroniser: 2-flop per bit on `btn_raw`.
- Tick: a free-running counter, 0..TICK_CYCLES-1, pulses `tick` for one cycle at wrap.
- Debounce, per bit:
  - On `tick`, shift the synchronised sample into a DEB_SAMPLES-deep history.
  - Debounced state goes to 1 when the history is all ones, and to 0 when it is all zeros; otherwise it holds.
  - A 0→1 change of debounced state produces `press_pulse` for exactly one cycle. Releases produce no output.
- Latch, per bit i:
  - `press_pulse[i]` with `working`=1 sets `button[i]` and `new[i]`.
  - `clear[i]` clears `button[i]` and `new[i]`.
  - Set and clear in the same cycle: set wins.
  - `working`=0 forces `button` and `new` to 0 and discards presses. Debounce continues to run.
- Offer FSM, states IDLE and OFFER:
  - IDLE → OFFER when `new` is nonzero and `working`=1. `req_idx` loads the lowest set index of `new`, and `req_valid` goes to 1.
  - OFFER with `req_ready`=1: clear `new[req_idx]`, go to IDLE. The next offer can appear no earlier than 2 cycles later.
  - While in OFFER, `req_idx` and `req_valid` stay stable until `req_ready`, even if a lower-index press arrives.
  - OFFER with `clear[req_idx]`=1 and no press on that bit in the same cycle: withdraw, go to IDLE, `req_valid` goes to 0.
  - `working`=0 in any state: go to IDLE, `req_valid`=0.

## Timing
- Reset values:
  - `button`, `press_pulse`, `req_valid`, `req_idx`: all 0.
  - Synchronisers, histories and debounced states: 0 (released).
  - Tick counter: 0. FSM state: IDLE.
- Raw edge to debounced change: 2 synchroniser cycles, plus DEB_SAMPLES ticks, plus 1 cycle. Worst case ≈ (DEB_SAMPLES+1)·TICK_CYCLES+3 cycles.
- Press pulse visible in cycle T:
  - `button[i]` is 1 from T+1.
  - `req_valid` is 1 from T+2, when the FSM is idle.
- `clear` takes effect on `button` in the next cycle.
- Handshake completes on any rising edge where `req_valid`=1 and `req_ready`=1. `req_ready` while `req_valid`=0 is ignored.
- A glitch shorter than DEB_SAMPLES consecutive ticks never produces a pulse.

## Configuration
- `CALL_CANCEL_EN` defined:
  - A press on a bit whose `button` is already 1 cancels it: clears `button[i]` and `new[i]`, with no offer.
  - If that bit is the one currently offered, `req_valid` drops next cycle.
- `CALL_CANCEL_EN` undefined: a re-press of a latched bit is ignored (no state change), and `press_pulse` still fires.

## Structure
- Shared package `elevator_pkg`:
  - `N_BTN` default.
  - Offer FSM state enum: IDLE, OFFER.
  - Lowest-set-bit priority function, also used by the controller.
- Sub-module `btn_debounce`: one bit, containing the synchroniser, history and pulse logic, taking `tick` as input. Instantiated N_BTN times with generate. The tick counter lives in `call_input`.

## Test plan
Bench values: TICK_CYCLES=4, DEB_SAMPLES=4.
- Clean press: hold `btn_raw[3]` high 40 cycles, `working`=1, `req_ready`=0.
  - One `press_pulse[3]`.
  - `button`=16'h0008.
  - `req_valid`=1 with `req_idx`=3, held stable.
- Bounce: toggle `btn_raw[5]` every 6 cycles for 60 cycles, then release.
  - No `press_pulse[5]`; `button` stays 0.
- Ordering: press bits 9 and 2 together, `req_ready`=1.
  - Offers `req_idx`=2, then `req_idx`=9, each for one handshake.
  - `button`=16'h0204 until cleared.
- Stability: offer idx 7 with `req_ready`=0, then press bit 1. `req_idx` stays 7; after the handshake, `req_idx`=1.
- Clear/withdraw:
  - `clear[7]` during the offer of idx 7 → `req_valid`=0 and `button[7]`=0 next cycle.
  - `clear[4]` coincident with `press_pulse[4]` → `button[4]`=1.
- Working/reset/config:
  - `working`=0 mid-offer → `button`=0 and `req_valid`=0 next cycle.
  - `rst_n` low asynchronously → all outputs 0 without waiting for a clock edge.
  - With `CALL_CANCEL_EN`, a second press of bit 3 → `button[3]`=0.
